// File: rtl/image_bank_loader_if.sv
// Pixel stream + 5-bank write bus between a pixel feeder, the bank loader
// and the row-interleaved buffer banks.
//   pix_valid/pix_data/pix_ready : raster-order pixel stream (valid/ready)
//   wr_en_5P                     : per-bank write strobe, at most one bit set
//   wr_addr_out_5P               : bank b at [ADDR_W*(b+1)-1 : ADDR_W*b]
//   wr_data_out_5P               : bank b at [DATA_W*(b+1)-1 : DATA_W*b]
// master = feeder/bank side, slave = loader.
interface image_bank_loader_if #(
  parameter int BANK_NUM = 5,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 16
);
  logic                       pix_valid;
  logic [DATA_W-1:0]          pix_data;
  logic                       pix_ready;
  logic [BANK_NUM-1:0]        wr_en_5P;
  logic [BANK_NUM*ADDR_W-1:0] wr_addr_out_5P;
  logic [BANK_NUM*DATA_W-1:0] wr_data_out_5P;

  modport master (
    output pix_valid, pix_data,
    input  pix_ready, wr_en_5P, wr_addr_out_5P, wr_data_out_5P
  );

  modport slave (
    input  pix_valid, pix_data,
    output pix_ready, wr_en_5P, wr_addr_out_5P, wr_data_out_5P
  );
endinterface

// File: rtl/image_bank_loader.sv
// image_bank_loader: takes one raster-order frame of H_IMAGE_LEN x V_IMAGE_LEN
// pixels and scatters it into BANK_NUM row-interleaved banks (row r -> bank
// r mod BANK_NUM, word (r div BANK_NUM)*H_IMAGE_LEN + c), then raises
// layer_en to C1S2 until it reports layer_finished.
// Ports:
//   clk            : clock, rising edge
//   rst_n          : synchronous reset, ACTIVE HIGH despite the name
//   start          : pulse, arms a new frame (honoured in IDLE only)
//   bus            : pixel stream in, per-bank write bus out (slave modport)
//   frame_done     : pulse with the final write strobe
//   layer_en       : level enable to C1S2, from the cycle after the final write
//   layer_finished : C1S2 work_finished, returns the loader to IDLE
//   busy           : high whenever not IDLE

// One bank's registered write port: strobe for a single cycle, address and
// data hold their last written values otherwise.
module image_bank_loader_slice #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    en_d   = sel;
    addr_d = addr_q;
    data_d = data_q;
    if (sel) begin
      addr_d = addr;
      data_d = data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign wr_en   = en_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
endmodule

module image_bank_loader #(
  parameter int H_IMAGE_LEN = 35,
  parameter int V_IMAGE_LEN = 35,
  parameter int BANK_NUM    = 5,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  image_bank_loader_if.slave  bus,
  output logic                frame_done,
  output logic                layer_en,
  input  logic                layer_finished,
  output logic                busy
);
  localparam int COL_W  = $clog2(H_IMAGE_LEN);
  localparam int ROW_W  = $clog2(V_IMAGE_LEN);
  localparam int BANK_W = $clog2(BANK_NUM);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_IMAGE_LEN - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_IMAGE_LEN - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(BANK_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HANDOFF} state_t;

  typedef struct packed {
    logic              vld;
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] base_q, base_d;   // word offset of the current row group
  logic              frame_done_q, frame_done_d;
  logic              layer_en_q, layer_en_d;

  logic              accept, last_pix;
  wr_req_t           req;
  logic [BANK_NUM-1:0]             sel;
  logic [BANK_NUM-1:0]             wr_en;
  logic [BANK_NUM-1:0][ADDR_W-1:0] wr_addr;
  logic [BANK_NUM-1:0][DATA_W-1:0] wr_data;

  assign accept   = (state_q == S_LOAD) && bus.pix_valid;
  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    req.vld  = accept;
    req.bank = bank_q;
    req.addr = base_q + ADDR_W'(col_q);
    req.data = bus.pix_data;
    sel      = '0;
    for (int b = 0; b < BANK_NUM; b++)
      sel[b] = req.vld && (req.bank == BANK_W'(b));
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    bank_d       = bank_q;
    base_d       = base_q;
    frame_done_d = 1'b0;
    layer_en_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          row_d   = '0;
          col_d   = '0;
          bank_d  = '0;
          base_d  = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            // Bank rotates every row; the row-group base steps only when
            // all banks have taken a row, replacing a divide by BANK_NUM.
            if (bank_q == BANK_LAST) begin
              bank_d = '0;
              base_d = base_q + ADDR_W'(H_IMAGE_LEN);
            end else begin
              bank_d = bank_q + BANK_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (last_pix) begin
            state_d      = S_HANDOFF;
            frame_done_d = 1'b1;   // lines up with the final registered strobe
            bank_d       = '0;
            base_d       = '0;
          end
        end
      end
      S_HANDOFF: begin
        // layer_en is registered off the state, so it first rises one cycle
        // after the final strobe, once that write has landed in its bank.
        if (layer_finished) state_d = S_IDLE;
        else                layer_en_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      bank_q       <= '0;
      base_q       <= '0;
      frame_done_q <= 1'b0;
      layer_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      bank_q       <= bank_d;
      base_q       <= base_d;
      frame_done_q <= frame_done_d;
      layer_en_q   <= layer_en_d;
    end
  end

  image_bank_loader_slice #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slice [BANK_NUM-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .addr    (req.addr),
    .data    (req.data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  assign bus.pix_ready      = (state_q == S_LOAD);
  assign bus.wr_en_5P       = wr_en;
  assign bus.wr_addr_out_5P = wr_addr;
  assign bus.wr_data_out_5P = wr_data;
  assign frame_done         = frame_done_q;
  assign layer_en           = layer_en_q;
  assign busy               = (state_q != S_IDLE);
endmodule

// File: tb/tb_image_bank_loader.sv
module tb_image_bank_loader;
  localparam int H = 35, V = 35, NB = 5, AW = 32, DW = 16;
  localparam int NPIX = H * V, DEPTH = 245, LOGN = 2600;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic layer_finished = 1'b0;
  logic frame_done, layer_en, busy;

  image_bank_loader_if #(.BANK_NUM(NB), .ADDR_W(AW), .DATA_W(DW)) bus ();

  image_bank_loader #(.H_IMAGE_LEN(H), .V_IMAGE_LEN(V), .BANK_NUM(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.slave),
    .frame_done(frame_done), .layer_en(layer_en), .layer_finished(layer_finished), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Write recorder: a bank-memory image plus an ordered log of strobes.
  logic [DW-1:0] mem [NB][DEPTH];
  int wb [LOGN], wa [LOGN], wd [LOGN];
  int strobes, multi, spurious, missing, oob, fd_cnt, fd_bad, le_bad;
  bit acc_prev, fd_prev, le_prev;

  always @(negedge clk) begin
    if (bus.wr_en_5P !== '0) begin
      if ($countones(bus.wr_en_5P) != 1) multi++;
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_en_5P[b]) begin
          if (strobes < LOGN) begin
            wb[strobes] = b;
            wa[strobes] = int'(bus.wr_addr_out_5P[b*AW +: AW]);
            wd[strobes] = int'(bus.wr_data_out_5P[b*DW +: DW]);
          end
          if (bus.wr_addr_out_5P[b*AW +: AW] < DEPTH)
            mem[b][bus.wr_addr_out_5P[b*AW +: AW]] = bus.wr_data_out_5P[b*DW +: DW];
          else oob++;
          strobes++;
        end
      end
      if (!acc_prev) spurious++;
    end else if (acc_prev) missing++;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      if (bus.wr_en_5P !== 5'b10000 || bus.wr_addr_out_5P[4*AW +: AW] !== 32'd244) fd_bad++;
    end
    if (layer_en === 1'b1 && !le_prev && !fd_prev) le_bad++;
    le_prev  = (layer_en === 1'b1);
    fd_prev  = (frame_done === 1'b1);
    acc_prev = (bus.pix_valid === 1'b1) && (bus.pix_ready === 1'b1) && (rst_n === 1'b0);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clear_log();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) mem[b][a] = 'x;
    strobes = 0; multi = 0; spurious = 0; missing = 0; oob = 0;
    fd_cnt = 0; fd_bad = 0; le_bad = 0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic finish_handoff();
    layer_finished = 1'b1; tick(); layer_finished = 1'b0;
  endtask

  // Offers pixels first..first+n-1 (data = index + off); gap_pct% of cycles idle.
  task automatic feed(input int first, input int n, input int off, input int gap_pct,
                      output bit ok, output int cycles);
    int sent = 0;
    bit v, acc;
    cycles = 0;
    while (sent < n && cycles < 20000) begin
      v = ($urandom_range(99) >= gap_pct);
      bus.pix_valid = v;
      bus.pix_data  = DW'(first + sent + off);
      acc = v && (bus.pix_ready === 1'b1);
      tick();
      if (acc) sent++;
      cycles++;
    end
    bus.pix_valid = 1'b0;
    ok = (sent == n);
  endtask

  // Independent reference: pixel i -> (r mod 5, (r div 5)*35 + c).
  function automatic int mem_errs(input int off);
    int e = 0, r, c;
    for (int i = 0; i < NPIX; i++) begin
      r = i / H; c = i % H;
      if (mem[r % NB][(r / NB) * H + c] !== DW'(i + off)) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; bus.pix_valid = 1'b0; bus.pix_data = '0;
    repeat (3) tick();
    n_cmp++; if (bus.pix_ready !== 1'b0) begin n_bad++; $display("FAIL reset_pix_ready: got %b want 0", bus.pix_ready); end
    n_cmp++; if (bus.wr_en_5P !== '0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en_5P); end
    n_cmp++; if (bus.wr_addr_out_5P !== '0) begin n_bad++; $display("FAIL reset_wr_addr: got %h want 0", bus.wr_addr_out_5P); end
    n_cmp++; if (bus.wr_data_out_5P !== '0) begin n_bad++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data_out_5P); end
    n_cmp++; if ({frame_done, layer_en, busy} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl: got %b want 000", {frame_done, layer_en, busy}); end
    rst_n = 1'b0; tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    clear_log();
  endtask

  task automatic test_frame();
    bit ok; int cyc;
    do_start();
    feed(0, NPIX, 0, 0, ok, cyc);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL frame_feed: accepted too few pixels in %0d cycles", cyc); end
    n_cmp++; if (cyc !== NPIX) begin n_bad++; $display("FAIL frame_cycles: got %0d want %0d", cyc, NPIX); end
    n_cmp++; if ({frame_done, bus.wr_en_5P} !== 6'b1_10000) begin n_bad++; $display("FAIL frame_done_with_strobe: got %b want 110000", {frame_done, bus.wr_en_5P}); end
    n_cmp++; if ({layer_en, bus.pix_ready, busy} !== 3'b001) begin n_bad++; $display("FAIL handoff_entry: got %b want 001", {layer_en, bus.pix_ready, busy}); end
    tick();
    n_cmp++; if ({frame_done, layer_en, bus.wr_en_5P} !== 7'b0_1_00000) begin n_bad++; $display("FAIL layer_en_rise: got %b want 0100000", {frame_done, layer_en, bus.wr_en_5P}); end
    settle();
    n_cmp++; if (strobes !== NPIX) begin n_bad++; $display("FAIL frame_strobes: got %0d want %0d", strobes, NPIX); end
    n_cmp++; if ({wb[0], wa[0], wd[0]} !== {32'd0, 32'd0, 32'd0}) begin n_bad++; $display("FAIL pix0: got b%0d a%0d d%0d want b0 a0 d0", wb[0], wa[0], wd[0]); end
    n_cmp++; if ({wb[35], wa[35], wd[35]} !== {32'd1, 32'd0, 32'd35}) begin n_bad++; $display("FAIL pix35: got b%0d a%0d d%0d want b1 a0 d35", wb[35], wa[35], wd[35]); end
    n_cmp++; if ({wb[175], wa[175], wd[175]} !== {32'd0, 32'd35, 32'd175}) begin n_bad++; $display("FAIL pix175: got b%0d a%0d d%0d want b0 a35 d175", wb[175], wa[175], wd[175]); end
    n_cmp++; if ({wb[1224], wa[1224], wd[1224]} !== {32'd4, 32'd244, 32'd1224}) begin n_bad++; $display("FAIL pix1224: got b%0d a%0d d%0d want b4 a244 d1224", wb[1224], wa[1224], wd[1224]); end
    n_cmp++; if (mem_errs(0) !== 0) begin n_bad++; $display("FAIL frame_mem: %0d bad words want 0", mem_errs(0)); end
    n_cmp++; if ({multi, spurious, missing, oob} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin n_bad++; $display("FAIL frame_strobe_shape: multi %0d spur %0d miss %0d oob %0d want 0", multi, spurious, missing, oob); end
    n_cmp++; if ({fd_cnt, fd_bad, le_bad} !== {32'd1, 32'd0, 32'd0}) begin n_bad++; $display("FAIL frame_pulses: fd %0d fd_bad %0d le_bad %0d want 1 0 0", fd_cnt, fd_bad, le_bad); end
  endtask

  task automatic test_handoff_hold();
    int bad = 0;
    repeat (100) begin
      tick();
      if (layer_en !== 1'b1 || bus.pix_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL handoff_hold: %0d bad cycles want 0", bad); end
    finish_handoff();
    n_cmp++; if ({layer_en, busy, bus.pix_ready} !== 3'b000) begin n_bad++; $display("FAIL handoff_exit: got %b want 000", {layer_en, busy, bus.pix_ready}); end
  endtask

  task automatic test_gaps();
    bit ok; int cyc;
    clear_log();
    do_start();
    feed(0, NPIX, 0, 50, ok, cyc);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL gaps_feed: accepted too few pixels in %0d cycles", cyc); end
    n_cmp++; if (cyc <= NPIX) begin n_bad++; $display("FAIL gaps_present: got %0d cycles want > %0d", cyc, NPIX); end
    tick(); settle();
    n_cmp++; if (strobes !== NPIX) begin n_bad++; $display("FAIL gaps_strobes: got %0d want %0d", strobes, NPIX); end
    n_cmp++; if ({spurious, missing, multi} !== {32'd0, 32'd0, 32'd0}) begin n_bad++; $display("FAIL gaps_strobe_shape: spur %0d miss %0d multi %0d want 0", spurious, missing, multi); end
    n_cmp++; if (mem_errs(0) !== 0) begin n_bad++; $display("FAIL gaps_mem: %0d bad words want 0", mem_errs(0)); end
    n_cmp++; if ({fd_cnt, le_bad, layer_en} !== {32'd1, 32'd0, 1'b1}) begin n_bad++; $display("FAIL gaps_handoff: fd %0d le_bad %0d layer_en %b want 1 0 1", fd_cnt, le_bad, layer_en); end
    finish_handoff();
  endtask

  task automatic test_ignored();
    bit ok; int cyc;
    clear_log();
    bus.pix_valid = 1'b1; bus.pix_data = 16'hBEEF; layer_finished = 1'b1;
    repeat (3) tick();
    layer_finished = 1'b0;
    n_cmp++; if ({busy, bus.pix_ready} !== 2'b00) begin n_bad++; $display("FAIL idle_ignores: got %b want 00", {busy, bus.pix_ready}); end
    start = 1'b1; tick(); start = 1'b0; bus.pix_valid = 1'b0;
    n_cmp++; if ({busy, bus.pix_ready} !== 2'b11) begin n_bad++; $display("FAIL start_to_load: got %b want 11", {busy, bus.pix_ready}); end
    settle();
    n_cmp++; if (strobes !== 0) begin n_bad++; $display("FAIL idle_pixel_written: got %0d strobes want 0", strobes); end
    feed(0, 500, 0, 0, ok, cyc);
    start = 1'b1; tick(); start = 1'b0;
    start = 1'b1; feed(500, 1, 0, 0, ok, cyc); start = 1'b0;
    feed(501, NPIX - 501, 0, 0, ok, cyc);
    n_cmp++; if ({ok, frame_done} !== 2'b11) begin n_bad++; $display("FAIL load_start_ignored: ok %b frame_done %b want 1 1", ok, frame_done); end
    tick();
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if ({layer_en, busy, bus.pix_ready} !== 3'b110) begin n_bad++; $display("FAIL handoff_start_ignored: got %b want 110", {layer_en, busy, bus.pix_ready}); end
    settle();
    n_cmp++; if (strobes !== NPIX || mem_errs(0) !== 0) begin n_bad++; $display("FAIL ignored_frame: strobes %0d bad %0d want %0d 0", strobes, mem_errs(0), NPIX); end
    start = 1'b1; layer_finished = 1'b1; tick(); start = 1'b0; layer_finished = 1'b0;
    n_cmp++; if ({layer_en, busy} !== 2'b00) begin n_bad++; $display("FAIL start_finish_together: got %b want 00", {layer_en, busy}); end
    tick();
    n_cmp++; if ({busy, bus.pix_ready} !== 2'b00) begin n_bad++; $display("FAIL start_dropped: got %b want 00", {busy, bus.pix_ready}); end
  endtask

  task automatic test_reset_midframe();
    bit ok; int cyc;
    clear_log();
    do_start();
    feed(0, 600, 0, 0, ok, cyc);
    bus.pix_valid = 1'b1; bus.pix_data = 16'd600; rst_n = 1'b1;
    tick();
    n_cmp++; if ({bus.pix_ready, bus.wr_en_5P, frame_done, layer_en, busy} !== 9'b0) begin n_bad++; $display("FAIL midreset_ctrl: got %b want 0", {bus.pix_ready, bus.wr_en_5P, frame_done, layer_en, busy}); end
    n_cmp++; if (bus.wr_addr_out_5P !== '0 || bus.wr_data_out_5P !== '0) begin n_bad++; $display("FAIL midreset_bus: addr %h data %h want 0", bus.wr_addr_out_5P, bus.wr_data_out_5P); end
    rst_n = 1'b0; bus.pix_valid = 1'b0;
    tick(); settle();
    n_cmp++; if ({strobes, spurious} !== {32'd600, 32'd0}) begin n_bad++; $display("FAIL midreset_strobes: got %0d spur %0d want 600 0", strobes, spurious); end
    clear_log();
    do_start();
    feed(0, NPIX, 0, 0, ok, cyc);
    settle();
    n_cmp++; if ({wb[0], wa[0], wd[0]} !== {32'd0, 32'd0, 32'd0}) begin n_bad++; $display("FAIL postreset_pix0: got b%0d a%0d d%0d want b0 a0 d0", wb[0], wa[0], wd[0]); end
    n_cmp++; if (strobes !== NPIX || mem_errs(0) !== 0) begin n_bad++; $display("FAIL postreset_frame: strobes %0d bad %0d want %0d 0", strobes, mem_errs(0), NPIX); end
    tick();
    finish_handoff();
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2; int cyc;
    clear_log();
    do_start();
    feed(0, NPIX, 0, 0, ok1, cyc);
    tick();
    finish_handoff();
    do_start();
    feed(0, NPIX, 1000, 0, ok2, cyc);
    tick(); settle();
    n_cmp++; if ({ok1, ok2} !== 2'b11) begin n_bad++; $display("FAIL two_feeds: got %b want 11", {ok1, ok2}); end
    n_cmp++; if ({strobes, fd_cnt} !== {32'd2450, 32'd2}) begin n_bad++; $display("FAIL two_counts: strobes %0d fd %0d want 2450 2", strobes, fd_cnt); end
    n_cmp++; if ({wb[1225], wa[1225], wd[1225]} !== {32'd0, 32'd0, 32'd1000}) begin n_bad++; $display("FAIL second_pix0: got b%0d a%0d d%0d want b0 a0 d1000", wb[1225], wa[1225], wd[1225]); end
    n_cmp++; if ({wb[2449], wa[2449]} !== {32'd4, 32'd244}) begin n_bad++; $display("FAIL second_last: got b%0d a%0d want b4 a244", wb[2449], wa[2449]); end
    n_cmp++; if (mem_errs(1000) !== 0) begin n_bad++; $display("FAIL second_mem: %0d bad words want 0", mem_errs(1000)); end
    n_cmp++; if ({fd_bad, le_bad, spurious, missing} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin n_bad++; $display("FAIL two_shape: fd_bad %0d le_bad %0d spur %0d miss %0d want 0", fd_bad, le_bad, spurious, missing); end
    finish_handoff();
    n_cmp++; if ({busy, layer_en} !== 2'b00) begin n_bad++; $display("FAIL two_idle: got %b want 00", {busy, layer_en}); end
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    test_reset();
    test_frame();
    test_handoff_hold();
    test_gaps();
    test_ignored();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
